bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 18 +
 rtl/bus_arbiter_if.sv | 22 ++
 rtl/bus_arbiter_arb_pick.sv | 29 ++
 rtl/bus_arbiter.sv | 135 +++++++++++++
 tb/tb_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types for the ibus/dbus memory-port arbiter: FSM states, bus owner, bus widths.
package bus_arbiter_pkg;

    localparam int W_ADDR = 32;
    localparam int W_DATA = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IBUS = 1'b0,
        OWN_DBUS = 1'b1
    } owner_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Memory-side handshake bundle: master = arbiter side, slave = memory side.
interface bus_arbiter_if import bus_arbiter_pkg::*; ();

    logic              mem_req;
    logic [3:0]        mem_we;
    logic [W_ADDR-1:0] mem_addr;
    logic [W_DATA-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [W_DATA-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

endinterface

// File: rtl/bus_arbiter_arb_pick.sv
// Tie-break between ibus and dbus. ARB_ROUND_ROBIN_EN: tie goes to the bus not served
// last; otherwise dbus always wins a tie. Output is only meaningful when an en is high.
module arb_pick import bus_arbiter_pkg::*; (
    input  logic   ibus_en_i,
    input  logic   dbus_en_i,
    input  owner_e last_i,
    output owner_e win_o
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        win_o = OWN_DBUS;
        if (ibus_en_i && dbus_en_i)
            win_o = (last_i == OWN_IBUS) ? OWN_DBUS : OWN_IBUS;
        else if (ibus_en_i)
            win_o = OWN_IBUS;
    end
`else
    logic unused_last;
    assign unused_last = (last_i == OWN_DBUS);

    always_comb begin
        win_o = OWN_IBUS;
        if (dbus_en_i)
            win_o = OWN_DBUS;
    end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Shares one memory port between instruction and data buses, one access in flight.
// Optional ARB_ROUND_ROBIN_EN selects round-robin tie-break instead of fixed dbus priority.
module bus_arbiter import bus_arbiter_pkg::*; #(
    parameter int WAIT_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ibus_en,
    input  logic [W_ADDR-1:0] ibus_addr,
    output logic [W_DATA-1:0] ibus_rdata,
    output logic              ibus_stall,
    input  logic              dbus_en,
    input  logic [3:0]        dbus_we,
    input  logic [W_ADDR-1:0] dbus_addr,
    input  logic [W_DATA-1:0] dbus_wdata,
    output logic [W_DATA-1:0] dbus_rdata,
    output logic              dbus_stall,
    output logic              mem_req,
    output logic [3:0]        mem_we,
    output logic [W_ADDR-1:0] mem_addr,
    output logic [W_DATA-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [W_DATA-1:0] mem_rdata,
    output logic              bus_err
);

    localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                win, last;
    logic [W_ADDR-1:0]     addr_q, addr_d;
    logic [3:0]            we_q, we_d;
    logic [W_DATA-1:0]     wdata_q, wdata_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  done, tmo, fin;

    arb_pick u_pick (
        .ibus_en_i (ibus_en),
        .dbus_en_i (dbus_en),
        .last_i    (last),
        .win_o     (win)
    );

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_q <= OWN_IBUS;
        else if (state_q == IDLE && (ibus_en || dbus_en))
            last_q <= win;
    end
    assign last = last_q;
`else
    assign last = OWN_IBUS;
`endif

    // A real completion wins over a watchdog expiry landing on the same cycle.
    assign done = (state_q == REQ  && mem_addr_ok && mem_data_ok) ||
                  (state_q == WAIT && mem_data_ok);
    assign tmo  = (state_q != IDLE) && (&cnt_q) && !done;
    assign fin  = done || tmo;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ibus_en || dbus_en) begin
                    state_d = REQ;
                    owner_d = win;
                    cnt_d   = '0;
                    if (win == OWN_DBUS) begin
                        addr_d  = dbus_addr;
                        we_d    = dbus_we;
                        wdata_d = dbus_wdata;
                    end else begin
                        addr_d  = ibus_addr;
                        we_d    = 4'b0000;
                        wdata_d = '0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_ONE;
                if (fin)
                    state_d = IDLE;
                else if (mem_addr_ok)
                    state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (fin)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IBUS;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign bus_err   = tmo;

    // On timeout the owner is released with zero data rather than the bus contents.
    assign ibus_rdata = (done && owner_q == OWN_IBUS) ? mem_rdata : '0;
    assign dbus_rdata = (done && owner_q == OWN_DBUS) ? mem_rdata : '0;
    assign ibus_stall = ibus_en && !(fin && owner_q == OWN_IBUS);
    assign dbus_stall = dbus_en && !(fin && owner_q == OWN_DBUS);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (WAIT_CNT_W = 3); tie order follows ARB_ROUND_ROBIN_EN.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_en, dbus_en, ibus_stall, dbus_stall, bus_err;
    logic [31:0] ibus_addr, ibus_rdata, dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_we;
    int          checks = 0;
    int          errors = 0;
    owner_e      exp_ord [3];

    bus_arbiter_if mif ();

    always #5 clk = ~clk;

    bus_arbiter #(.WAIT_CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .ibus_en     (ibus_en),
        .ibus_addr   (ibus_addr),
        .ibus_rdata  (ibus_rdata),
        .ibus_stall  (ibus_stall),
        .dbus_en     (dbus_en),
        .dbus_we     (dbus_we),
        .dbus_addr   (dbus_addr),
        .dbus_wdata  (dbus_wdata),
        .dbus_rdata  (dbus_rdata),
        .dbus_stall  (dbus_stall),
        .mem_req     (mif.mem_req),
        .mem_we      (mif.mem_we),
        .mem_addr    (mif.mem_addr),
        .mem_wdata   (mif.mem_wdata),
        .mem_addr_ok (mif.mem_addr_ok),
        .mem_data_ok (mif.mem_data_ok),
        .mem_rdata   (mif.mem_rdata),
        .bus_err     (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ibus_en = 0; ibus_addr = 0;
        dbus_en = 0; dbus_we = 0; dbus_addr = 0; dbus_wdata = 0;
        mif.mem_addr_ok = 0; mif.mem_data_ok = 0; mif.mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_in();
        step();
        step();
        rst = 0;
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_ord = '{OWN_DBUS, OWN_IBUS, OWN_DBUS};
`else
        exp_ord = '{OWN_DBUS, OWN_DBUS, OWN_DBUS};
`endif
        // reset state, with ibus_en high to see the en-driven stall
        rst = 1;
        clear_in();
        ibus_en = 1;
        step();
        chk("rst_req",    {31'd0, mif.mem_req}, 0);
        chk("rst_addr",   mif.mem_addr, 0);
        chk("rst_we",     {28'd0, mif.mem_we}, 0);
        chk("rst_wdata",  mif.mem_wdata, 0);
        chk("rst_err",    {31'd0, bus_err}, 0);
        chk("rst_istall", {31'd0, ibus_stall}, 1);
        chk("rst_dstall", {31'd0, dbus_stall}, 0);
        chk("rst_irdata", ibus_rdata, 0);

        // single load: addr_ok cycle 1, data_ok cycle 3
        do_reset();
        dbus_en = 1; dbus_addr = 32'h1000; dbus_we = 4'b0000;
        #1;
        chk("ld_c0_req",   {31'd0, mif.mem_req}, 0);
        chk("ld_c0_stall", {31'd0, dbus_stall}, 1);
        step();
        mif.mem_addr_ok = 1;
        #1;
        chk("ld_c1_req",   {31'd0, mif.mem_req}, 1);
        chk("ld_c1_addr",  mif.mem_addr, 32'h1000);
        chk("ld_c1_we",    {28'd0, mif.mem_we}, 0);
        chk("ld_c1_stall", {31'd0, dbus_stall}, 1);
        step();
        mif.mem_addr_ok = 0;
        #1;
        chk("ld_c2_req",   {31'd0, mif.mem_req}, 0);
        chk("ld_c2_stall", {31'd0, dbus_stall}, 1);
        step();
        mif.mem_data_ok = 1; mif.mem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_c3_stall", {31'd0, dbus_stall}, 0);
        chk("ld_c3_rdata", dbus_rdata, 32'hDEADBEEF);
        chk("ld_c3_irdat", ibus_rdata, 0);
        step();
        clear_in();
        #1;
        chk("ld_c4_rdata", dbus_rdata, 0);
        chk("ld_c4_req",   {31'd0, mif.mem_req}, 0);

        // store held in REQ until addr_ok
        do_reset();
        dbus_en = 1; dbus_we = 4'b0011; dbus_wdata = 32'h0000ABCD; dbus_addr = 32'h2004;
        step();
        #1;
        chk("st_c1_req",   {31'd0, mif.mem_req}, 1);
        chk("st_c1_we",    {28'd0, mif.mem_we}, 32'h3);
        chk("st_c1_addr",  mif.mem_addr, 32'h2004);
        chk("st_c1_wdata", mif.mem_wdata, 32'h0000ABCD);
        step();
        mif.mem_addr_ok = 1; mif.mem_data_ok = 1;
        #1;
        chk("st_c2_req",   {31'd0, mif.mem_req}, 1);
        chk("st_c2_wdata", mif.mem_wdata, 32'h0000ABCD);
        chk("st_c2_stall", {31'd0, dbus_stall}, 0);
        step();
        clear_in();
        #1;
        chk("st_c3_req",   {31'd0, mif.mem_req}, 0);

        // simultaneous request right after reset: dbus first, ibus after the IDLE cycle
        do_reset();
        ibus_en = 1; ibus_addr = 32'h100; dbus_en = 1; dbus_addr = 32'h3000;
        step();
        mif.mem_addr_ok = 1; mif.mem_data_ok = 1; mif.mem_rdata = 32'h11111111;
        #1;
        chk("tie_d_addr",  mif.mem_addr, 32'h3000);
        chk("tie_d_dstl",  {31'd0, dbus_stall}, 0);
        chk("tie_d_rdata", dbus_rdata, 32'h11111111);
        chk("tie_d_istl",  {31'd0, ibus_stall}, 1);
        chk("tie_d_irdat", ibus_rdata, 0);
        step();
        dbus_en = 0; mif.mem_addr_ok = 0; mif.mem_data_ok = 0;
        #1;
        chk("tie_idle_req", {31'd0, mif.mem_req}, 0);
        chk("tie_idle_istl", {31'd0, ibus_stall}, 1);
        step();
        mif.mem_addr_ok = 1; mif.mem_data_ok = 1; mif.mem_rdata = 32'h22222222;
        #1;
        chk("tie_i_req",   {31'd0, mif.mem_req}, 1);
        chk("tie_i_addr",  mif.mem_addr, 32'h100);
        chk("tie_i_we",    {28'd0, mif.mem_we}, 0);
        chk("tie_i_rdata", ibus_rdata, 32'h22222222);
        chk("tie_i_istl",  {31'd0, ibus_stall}, 0);
        step();
        clear_in();

        // three consecutive ties, both requesters held high throughout
        do_reset();
        ibus_en = 1; ibus_addr = 32'h100; dbus_en = 1; dbus_addr = 32'h3000;
        for (int r = 0; r < 3; r++) begin
            #1;
            chk("rr_idle_req", {31'd0, mif.mem_req}, 0);
            step();
            mif.mem_addr_ok = 1; mif.mem_data_ok = 1; mif.mem_rdata = 32'h0 + r;
            #1;
            chk("rr_addr", mif.mem_addr, (exp_ord[r] == OWN_DBUS) ? 32'h3000 : 32'h100);
            chk("rr_dstall", {31'd0, dbus_stall}, (exp_ord[r] == OWN_DBUS) ? 0 : 1);
            chk("rr_istall", {31'd0, ibus_stall}, (exp_ord[r] == OWN_IBUS) ? 0 : 1);
            step();
            mif.mem_addr_ok = 0; mif.mem_data_ok = 0;
        end
        clear_in();

        // watchdog: 3-bit counter expires 7 cycles after entering REQ
        do_reset();
        ibus_en = 1; ibus_addr = 32'h40;
        step();
        mif.mem_addr_ok = 1; mif.mem_rdata = 32'hAAAAAAAA;
        #1;
        chk("wd_c1_err", {31'd0, bus_err}, 0);
        for (int n = 2; n <= 8; n++) begin
            step();
            mif.mem_addr_ok = 0;
            #1;
            chk("wd_req",   {31'd0, mif.mem_req}, 0);
            chk("wd_err",   {31'd0, bus_err}, (n == 8) ? 1 : 0);
            chk("wd_istl",  {31'd0, ibus_stall}, (n == 8) ? 0 : 1);
            chk("wd_irdat", ibus_rdata, 0);
        end
        step();
        #1;
        chk("wd_c9_err",  {31'd0, bus_err}, 0);
        chk("wd_c9_req",  {31'd0, mif.mem_req}, 0);
        chk("wd_c9_istl", {31'd0, ibus_stall}, 1);
        step();
        mif.mem_addr_ok = 1; mif.mem_data_ok = 1; mif.mem_rdata = 32'h33333333;
        #1;
        chk("wd_c10_req",   {31'd0, mif.mem_req}, 1);
        chk("wd_c10_rdata", ibus_rdata, 32'h33333333);
        step();
        clear_in();

        // reset asserted while in WAIT; the stray data_ok afterwards is ignored
        do_reset();
        dbus_en = 1; dbus_addr = 32'h5000;
        step();
        mif.mem_addr_ok = 1;
        #1;
        chk("rw_c1_req", {31'd0, mif.mem_req}, 1);
        step();
        mif.mem_addr_ok = 0;
        rst = 1;
        #1;
        chk("rw_req",   {31'd0, mif.mem_req}, 0);
        chk("rw_addr",  mif.mem_addr, 0);
        chk("rw_dstl",  {31'd0, dbus_stall}, 1);
        step();
        rst = 0;
        mif.mem_data_ok = 1; mif.mem_rdata = 32'h0BAD0BAD;
        #1;
        chk("rw_late_dstl",  {31'd0, dbus_stall}, 1);
        chk("rw_late_rdata", dbus_rdata, 0);
        chk("rw_late_err",   {31'd0, bus_err}, 0);
        step();
        mif.mem_data_ok = 0;
        mif.mem_addr_ok = 1; mif.mem_data_ok = 1; mif.mem_rdata = 32'h44444444;
        #1;
        chk("rw_retry_addr",  mif.mem_addr, 32'h5000);
        chk("rw_retry_rdata", dbus_rdata, 32'h44444444);
        step();
        clear_in();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
